tpu_seq_ctrl: RTL and testbench

- Parametrised memory-mapped sequencer for the next-generation TPU.
- Decodes host bus accesses into write strobes and row indices for the A buffer, B buffer and C/systolic array.
- Runs the matrix-multiply FSM with a bounded, self-clearing cycle counter and an optional accumulate mode.
- Exposes a readable status register, busy lockout, a sticky error flag and a done interrupt pulse.

---
 rtl/tpu_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_tpu_seq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl: memory-mapped sequencer for the TPU matrix-multiply datapath.
//
// Decodes host writes into A/B/C buffer strobes and row indices, runs the
// IDLE -> CLEAR -> RUN -> DONE matrix-multiply sequence, and exposes a status
// register with busy, sticky done/error flags, accumulate mode and the cycle
// count of the last run.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   r_w, addr, dataIn host access (r_w=1 write), byte address, write data
//   stat_rdata        status word, non-zero only while reading STAT_ADDR
//   a_wr_en, a_row    A buffer write strobe and row index
//   b_wr_en           B buffer write strobe
//   c_wr_en, c_row,   C buffer write strobe, row index and DATAW-word index
//   c_half              within the row
//   sys_en, sys_clr   systolic array advance enable and accumulator clear
//   busy, done_irq    run in progress, one-cycle completion pulse
//
// Optional build macro TPU_SEQ_PERF_EN adds a saturating 16-bit completed-run
// counter readable at stat_rdata[47:32].
module tpu_seq_ctrl #(
  parameter int unsigned       DIM       = 8,
  parameter int unsigned       BITS_AB   = 8,
  parameter int unsigned       BITS_C    = 16,
  parameter int unsigned       ADDRW     = 16,
  parameter int unsigned       DATAW     = 64,
  parameter logic [ADDRW-1:0]  BASE_A    = 'h0100,
  parameter logic [ADDRW-1:0]  BASE_B    = 'h0200,
  parameter logic [ADDRW-1:0]  BASE_C    = 'h0300,
  parameter logic [ADDRW-1:0]  CTRL_ADDR = 'h0400,
  parameter logic [ADDRW-1:0]  STAT_ADDR = 'h0408
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   r_w,
  input  logic [ADDRW-1:0]       addr,
  input  logic [DATAW-1:0]       dataIn,
  output logic [DATAW-1:0]       stat_rdata,
  output logic                   a_wr_en,
  output logic [$clog2(DIM)-1:0] a_row,
  output logic                   b_wr_en,
  output logic                   c_wr_en,
  output logic [$clog2(DIM)-1:0] c_row,
  output logic [((DIM*BITS_C/DATAW) > 1 ? $clog2(DIM*BITS_C/DATAW) : 1)-1:0] c_half,
  output logic                   sys_en,
  output logic                   sys_clr,
  output logic                   busy,
  output logic                   done_irq
);

  localparam int unsigned RowW     = $clog2(DIM);
  localparam int unsigned HalfRat  = DIM * BITS_C / DATAW;
  localparam int unsigned HalfW    = (HalfRat > 1) ? $clog2(HalfRat) : 1;
  localparam bit          HalfEn   = (HalfRat > 1);
  localparam int unsigned CntW     = $clog2(3 * DIM - 1);
  localparam int unsigned AbShift  = $clog2(DIM * BITS_AB / 8);
  localparam int unsigned CShift   = $clog2(DIM * BITS_C / 8);
  localparam int unsigned DwShift  = $clog2(DATAW / 8);
  localparam int unsigned SzAb     = DIM * DIM * BITS_AB / 8;
  localparam int unsigned SzC      = DIM * DIM * BITS_C / 8;

  localparam logic [ADDRW-1:0] SzAbW   = ADDRW'(SzAb);
  localparam logic [ADDRW-1:0] SzCW    = ADDRW'(SzC);
  // Count value seen during the final RUN cycle (3*DIM-2 cycles, from 0).
  localparam logic [CntW-1:0]  RunLast = CntW'(3 * DIM - 3);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            acc_q;
  logic            done_q;
  logic            err_q;
  logic [15:0]     last_q;
  logic [15:0]     perf_cnt;

  logic [ADDRW-1:0] off_a, off_b, off_c;
  logic             in_a, in_b, in_c;
  logic             idle, ctrl_wr, stat_rd, start, err_set;
  logic [63:0]      stat_word;

  // Address decode
  assign off_a = addr - BASE_A;
  assign off_b = addr - BASE_B;
  assign off_c = addr - BASE_C;
  assign in_a  = (addr >= BASE_A) && (off_a < SzAbW);
  assign in_b  = (addr >= BASE_B) && (off_b < SzAbW);
  assign in_c  = (addr >= BASE_C) && (off_c < SzCW);

  assign idle    = (state_q == StIdle);
  assign ctrl_wr = r_w && (addr == CTRL_ADDR);
  assign stat_rd = !r_w && (addr == STAT_ADDR);
  assign start   = ctrl_wr && idle && dataIn[0];

  // Any buffer/CTRL write while busy is dropped and flagged; a CTRL write
  // without the start bit is flagged and otherwise ignored.
  assign err_set = (r_w && !idle && (in_a || in_b || in_c || (addr == CTRL_ADDR))) ||
                   (ctrl_wr && idle && !dataIn[0]);

  assign a_wr_en = r_w && in_a && idle;
  assign b_wr_en = r_w && in_b && idle;
  assign c_wr_en = r_w && in_c && idle;

  // Row indices are only meaningful alongside their strobe; held at 0 otherwise.
  assign a_row  = a_wr_en ? off_a[AbShift +: RowW] : '0;
  assign c_row  = c_wr_en ? off_c[CShift +: RowW] : '0;
  assign c_half = (c_wr_en && HalfEn) ? off_c[DwShift +: HalfW] : '0;

  // FSM next state and outputs
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sys_en   = 1'b0;
    sys_clr  = 1'b0;
    done_irq = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) state_d = StClear;
      end
      StClear: begin
        sys_clr = !acc_q;
        count_d = '0;
        state_d = StRun;
      end
      StRun: begin
        sys_en  = 1'b1;
        count_d = count_q + 1'b1;
        if (count_q == RunLast) state_d = StDone;
      end
      StDone: begin
        done_irq = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Mode, stickies and last-run cycle count. Sets take priority over clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      last_q <= '0;
    end else begin
      if (start) acc_q <= dataIn[1];

      if (state_q == StDone)      done_q <= 1'b1;
      else if (stat_rd || start)  done_q <= 1'b0;

      if (err_set)      err_q <= 1'b1;
      else if (stat_rd) err_q <= 1'b0;

      if (state_q == StDone) last_q <= 16'(count_q);
    end
  end

`ifdef TPU_SEQ_PERF_EN
  logic [15:0] run_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
    end else if ((state_q == StDone) && (run_cnt_q != 16'hFFFF)) begin
      run_cnt_q <= run_cnt_q + 16'd1;
    end
  end

  assign perf_cnt = run_cnt_q;
`else
  assign perf_cnt = '0;
`endif

  assign stat_word  = {16'h0000, perf_cnt, last_q, 8'(DIM), 4'h0, acc_q, err_q, done_q, busy};
  assign stat_rdata = stat_rd ? DATAW'(stat_word) : '0;

  logic unused_bits;
  assign unused_bits = ^{dataIn, off_a, off_c};

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed self-checking bench for tpu_seq_ctrl (default parameters).
// Covers reset state, address decode boundaries, normal and accumulate runs,
// busy lockout with error flag, status read-clear, mid-run reset and the
// optional run counter.
module tb_tpu_seq_ctrl;

  localparam logic [15:0] Ctrl = 16'h0400;
  localparam logic [15:0] Stat = 16'h0408;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_w = 1'b0;
  logic [15:0] addr = '0;
  logic [63:0] dataIn = '0;
  logic [63:0] stat_rdata;
  logic        a_wr_en, b_wr_en, c_wr_en;
  logic [2:0]  a_row, c_row;
  logic [0:0]  c_half;
  logic        sys_en, sys_clr, busy, done_irq;

  int n_total = 0;
  int n_bad   = 0;
  int runs    = 0;

  always #5 clk = ~clk;

  tpu_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r_w        (r_w),
    .addr       (addr),
    .dataIn     (dataIn),
    .stat_rdata (stat_rdata),
    .a_wr_en    (a_wr_en),
    .a_row      (a_row),
    .b_wr_en    (b_wr_en),
    .c_wr_en    (c_wr_en),
    .c_row      (c_row),
    .c_half     (c_half),
    .sys_en     (sys_en),
    .sys_clr    (sys_clr),
    .busy       (busy),
    .done_irq   (done_irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Expected status word: flags = {acc, err, done, busy}.
  function automatic logic [63:0] mk_stat(input logic [15:0] last, input logic [3:0] flags,
                                          input int nruns);
    logic [15:0] perf;
`ifdef TPU_SEQ_PERF_EN
    perf = 16'(nruns);
`else
    perf = 16'h0000;
`endif
    return {16'h0000, perf, last, 8'h08, 4'h0, flags};
  endfunction

  task automatic read_stat(output logic [63:0] v);
    @(negedge clk);
    r_w = 1'b0; addr = Stat; dataIn = '0;
    #1 v = stat_rdata;
    @(negedge clk);
    addr = '0;
  endtask

  task automatic stat_is(input string tag, input logic [63:0] exp);
    logic [63:0] v;
    read_stat(v);
    check(tag, v, exp);
  endtask

  // Samples one busy window, one entry per cycle starting in the cycle after
  // the start write. mode 1 injects busy writes and a status read in DONE;
  // mode 2 asserts reset after ten RUN cycles.
  task automatic measure(input int mode, output int n_clr, output int n_en, output int n_irq,
                         output int n_busy, output int irq_idx, output logic [63:0] st_done);
    n_clr = 0; n_en = 0; n_irq = 0; n_busy = 60; irq_idx = -1; st_done = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      r_w = 1'b0; addr = '0; dataIn = '0;
      if (mode == 1 && i == 5) begin r_w = 1'b1; addr = 16'h0200; end
      if (mode == 1 && i == 6) begin r_w = 1'b1; addr = Ctrl; dataIn = 64'h1; end
      if (mode == 1 && i == 23) addr = Stat;
      if (mode == 2 && i == 11) rst_n = 1'b0;
      #1;
      if (mode == 2 && i == 11) begin
        check("rst_outputs", {busy, done_irq, sys_en, sys_clr, a_wr_en, b_wr_en, c_wr_en,
                              (stat_rdata != 0)}, 64'h0);
        n_busy = i;
        break;
      end
      if (!busy) begin
        n_busy = i;
        break;
      end
      if (sys_clr) n_clr++;
      if (sys_en) n_en++;
      if (done_irq) begin
        n_irq++;
        irq_idx = i;
      end
      if (mode == 1 && i == 5) check("busy_b_strobe", {63'h0, b_wr_en}, 64'h0);
      if (mode == 1 && i == 23) st_done = stat_rdata;
    end
  endtask

  task automatic run_check(input string tag, input logic [63:0] ctrl, input int mode,
                           input int exp_clr, input logic [63:0] exp_st);
    int n_clr, n_en, n_irq, n_busy, irq_idx;
    logic [63:0] st_done;
    @(negedge clk);
    r_w = 1'b1; addr = Ctrl; dataIn = ctrl;
    measure(mode, n_clr, n_en, n_irq, n_busy, irq_idx, st_done);
    check({tag, "_clr_cycles"}, 64'(n_clr), 64'(exp_clr));
    check({tag, "_en_cycles"}, 64'(n_en), 64'd22);
    check({tag, "_irq_cycles"}, 64'(n_irq), 64'd1);
    check({tag, "_busy_cycles"}, 64'(n_busy), 64'd24);
    check({tag, "_irq_position"}, 64'(irq_idx), 64'd23);
    if (mode == 1) check({tag, "_stat_in_done"}, st_done, exp_st);
    runs++;
  endtask

  typedef struct {
    logic        rw;
    logic [15:0] a;
    logic [2:0]  strb;   // {a, b, c}
    logic [2:0]  arow;
    logic [2:0]  crow;
    logic        half;
  } dec_t;

  dec_t dec_tbl[13] = '{
    '{1'b1, 16'h0105, 3'b100, 3'd0, 3'd0, 1'b0},
    '{1'b1, 16'h013F, 3'b100, 3'd7, 3'd0, 1'b0},
    '{1'b1, 16'h0118, 3'b100, 3'd3, 3'd0, 1'b0},
    '{1'b1, 16'h0140, 3'b000, 3'd0, 3'd0, 1'b0},
    '{1'b1, 16'h00FF, 3'b000, 3'd0, 3'd0, 1'b0},
    '{1'b1, 16'h0200, 3'b010, 3'd0, 3'd0, 1'b0},
    '{1'b1, 16'h023F, 3'b010, 3'd0, 3'd0, 1'b0},
    '{1'b1, 16'h0240, 3'b000, 3'd0, 3'd0, 1'b0},
    '{1'b1, 16'h037A, 3'b001, 3'd0, 3'd7, 1'b1},
    '{1'b1, 16'h0300, 3'b001, 3'd0, 3'd0, 1'b0},
    '{1'b1, 16'h0308, 3'b001, 3'd0, 3'd0, 1'b1},
    '{1'b1, 16'h0380, 3'b000, 3'd0, 3'd0, 1'b0},
    '{1'b0, 16'h0105, 3'b000, 3'd0, 3'd0, 1'b0}
  };

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {busy, done_irq, sys_en, sys_clr}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stat_is("reset_stat", mk_stat(16'd0, 4'b0000, 0));

    // Address decode
    foreach (dec_tbl[k]) begin
      @(negedge clk);
      r_w = dec_tbl[k].rw; addr = dec_tbl[k].a; dataIn = '0;
      #1;
      check($sformatf("decode_%h", dec_tbl[k].a),
            {a_wr_en, b_wr_en, c_wr_en, a_row, c_row, c_half},
            {dec_tbl[k].strb, dec_tbl[k].arow, dec_tbl[k].crow, dec_tbl[k].half});
    end
    @(negedge clk);
    r_w = 1'b0; addr = '0;
    #1 check("decode_no_start", {63'h0, busy}, 64'h0);

    // Normal run, then status read clears done
    run_check("run1", 64'h1, 0, 1, '0);
    stat_is("run1_stat", mk_stat(16'd22, 4'b0010, runs));
    stat_is("run1_stat_cleared", mk_stat(16'd22, 4'b0000, runs));

    // Accumulate run: no accumulator clear
    run_check("acc", 64'h3, 0, 0, '0);
    stat_is("acc_stat", mk_stat(16'd22, 4'b1010, runs));
    stat_is("acc_stat_cleared", mk_stat(16'd22, 4'b1000, runs));

    // Busy lockout: writes dropped, err set; read in DONE clears err while done sets
    run_check("lock", 64'h1, 1, 1, mk_stat(16'd22, 4'b0101, runs));
    stat_is("lock_stat", mk_stat(16'd22, 4'b0010, runs));
    stat_is("lock_stat_cleared", mk_stat(16'd22, 4'b0000, runs));

    // CTRL write without start bit: error only
    @(negedge clk);
    r_w = 1'b1; addr = Ctrl; dataIn = 64'h2;
    @(negedge clk);
    r_w = 1'b0; addr = '0; dataIn = '0;
    #1 check("nostart_busy", {63'h0, busy}, 64'h0);
    stat_is("nostart_stat", mk_stat(16'd22, 4'b0100, runs));
    stat_is("nostart_stat_cleared", mk_stat(16'd22, 4'b0000, runs));

    // Reset in the middle of RUN
    begin
      int n_clr, n_en, n_irq, n_busy, irq_idx;
      logic [63:0] st_done;
      @(negedge clk);
      r_w = 1'b1; addr = Ctrl; dataIn = 64'h1;
      measure(2, n_clr, n_en, n_irq, n_busy, irq_idx, st_done);
      check("rst_en_before", 64'(n_en), 64'd10);
      check("rst_irq_before", 64'(n_irq), 64'd0);
      @(negedge clk);
      #1 check("rst_hold_outputs", {busy, done_irq, sys_en, sys_clr}, 64'h0);
      rst_n = 1'b1;
      runs = 0;
    end
    stat_is("rst_stat", mk_stat(16'd0, 4'b0000, 0));
    run_check("after_rst", 64'h1, 0, 1, '0);
    stat_is("after_rst_stat", mk_stat(16'd22, 4'b0010, runs));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
